// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM states (used by transmit and receive
// FSMs), parity method encodings, FIFO level width and bit helpers.
package uart_pkg;

    typedef enum logic [4:0] {
        INTERVAL  = 5'b00001,
        STARTBIT  = 5'b00010,
        DATABITS  = 5'b00100,
        PARITYBIT = 5'b01000,
        STOPBIT   = 5'b10000
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int LEVEL_W = 16;

    // Data bit number idx of a frame, honouring the bit order.
    function automatic logic data_bit(input logic [7:0] byte_v,
                                      input logic [2:0] idx,
                                      input logic       big_end);
        return big_end ? byte_v[3'd7 - idx] : byte_v[idx];
    endfunction

    // Parity bit value that makes the count of ones even (or odd).
    function automatic logic parity_bit(input logic [7:0] byte_v,
                                        input logic       method);
        logic p;
        case (method)
            PARITY_EVEN: p = ^byte_v;
            PARITY_ODD:  p = ~(^byte_v);
            default:     p = ^byte_v;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: single clock, active-low write/read/clear strobes,
// separate 0..DEPTH level counter, empty/near-full/full flags and a sticky
// overflow flag. Read data is the current head (show-ahead).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 128,
    parameter int NEAR_GAP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_data,
    input  logic               n_we,
    input  logic               n_re,
    input  logic               n_clr,
    output logic [7:0]         o_data,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_empty,
    output logic               o_near_full,
    output logic               o_full,
    output logic               o_over
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] NEAR_LVL = LEVEL_W'(DEPTH - NEAR_GAP);

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_over;
    logic               w_re;
    logic               w_we;

    assign o_empty     = (r_level == '0);
    assign o_full      = (r_level == FULL_LVL);
    assign o_near_full = (r_level >= NEAR_LVL);
    assign o_level     = r_level;
    assign o_over      = r_over;
    assign o_data      = r_mem[r_rd_ptr];

    // A pop never happens on an empty FIFO; a write while full is only
    // accepted when a pop frees the slot in the same clock. Clear wins.
    assign w_re = ~n_re & ~o_empty & n_clr;
    assign w_we = ~n_we & n_clr & (~o_full | w_re);

    // Pointers, level counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_over   <= 1'b0;
        end else if (!n_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_over   <= 1'b0;
        end else begin
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_we && !w_re)      r_level <= r_level + 1'b1;
            else if (w_re && !w_we) r_level <= r_level - 1'b1;
            if (!n_we && o_full && !w_re) r_over <= 1'b1;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: byte FIFO plus a one-hot frame FSM that serialises
// start, 8 data bits, optional parity and stop bit on each BaudSig_i pulse.
// Optional macro UART_TX_TWO_STOP_EN adds p_TwoStop_i (two stop periods).
// State_o exposes the FSM state for observation.
// Handshake: n_We_i is a 1-clk active-low strobe accepted unless the FIFO is
// full (with no pop in the same clock) or n_Clr_i is low.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DEPTH    = 128,
    parameter int NEAR_GAP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         Data_i,
    input  logic               n_We_i,
    input  logic               n_Clr_i,
    input  logic               p_Enable_i,
    input  logic               p_ParityEnable_i,
    input  logic               p_BigEnd_i,
    input  logic               ParityMethod_i,
    input  logic               BaudSig_i,
`ifdef UART_TX_TWO_STOP_EN
    input  logic               p_TwoStop_i,
`endif
    output logic               p_Empty_o,
    output logic               p_NearFull_o,
    output logic               p_Full_o,
    output logic               p_Over_o,
    output logic [LEVEL_W-1:0] TxFifoLevel_o,
    output logic               p_Busy_o,
    output logic               p_ByteSent_o,
    output logic               Tx_o,
    output uart_state_e        State_o
);

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [7:0]  w_fifo_data;
    logic [7:0]  r_byte;
    logic [2:0]  r_bitcnt;
    logic [2:0]  w_bitcnt_nxt;
    logic        r_par_en;
    logic        r_big_end;
    logic        r_parity;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_sent;
    logic        w_sent_nxt;
    logic        w_pop;
    logic        w_extra_stop;

    uart_tx_fifo #(
        .DEPTH    (DEPTH),
        .NEAR_GAP (NEAR_GAP)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_data      (Data_i),
        .n_we        (n_We_i),
        .n_re        (~w_pop),
        .n_clr       (n_Clr_i),
        .o_data      (w_fifo_data),
        .o_level     (TxFifoLevel_o),
        .o_empty     (p_Empty_o),
        .o_near_full (p_NearFull_o),
        .o_full      (p_Full_o),
        .o_over      (p_Over_o)
    );

    assign Tx_o         = r_tx;
    assign p_ByteSent_o = r_sent;
    assign p_Busy_o     = (r_state != INTERVAL);
    assign State_o      = r_state;

`ifdef UART_TX_TWO_STOP_EN
    logic r_two_stop;
    logic r_stop_second;

    // Two-stop option latched at pop; second-period marker inside STOPBIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_two_stop    <= 1'b0;
            r_stop_second <= 1'b0;
        end else begin
            if (w_pop) r_two_stop <= p_TwoStop_i;
            if (BaudSig_i && r_state == STOPBIT) r_stop_second <= w_extra_stop;
        end
    end

    assign w_extra_stop = r_two_stop & ~r_stop_second;
`else
    assign w_extra_stop = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= INTERVAL;
        else      r_state <= w_state_nxt;
    end

    // Next state, line value, bit counter, pop and byte-sent decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_bitcnt_nxt = r_bitcnt;
        w_sent_nxt   = 1'b0;
        w_pop        = 1'b0;
        if (BaudSig_i) begin
            unique case (r_state)
                INTERVAL: begin
                    if (p_Enable_i && !p_Empty_o) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = STARTBIT;
                    end
                end
                STARTBIT: begin
                    w_tx_nxt     = data_bit(r_byte, 3'd0, r_big_end);
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = DATABITS;
                end
                DATABITS: begin
                    if (r_bitcnt == 3'd7) begin
                        if (r_par_en) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = PARITYBIT;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = STOPBIT;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        w_tx_nxt     = data_bit(r_byte, r_bitcnt + 3'd1, r_big_end);
                    end
                end
                PARITYBIT: begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = STOPBIT;
                end
                STOPBIT: begin
                    w_tx_nxt = 1'b1;
                    if (!w_extra_stop) begin
                        w_sent_nxt = 1'b1;
                        if (p_Enable_i && !p_Empty_o) begin
                            w_pop       = 1'b1;
                            w_tx_nxt    = 1'b0;
                            w_state_nxt = STARTBIT;
                        end else begin
                            w_state_nxt = INTERVAL;
                        end
                    end
                end
                default: begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = INTERVAL;
                end
            endcase
        end
    end

    // Registered line, pulse, counter and per-byte latched settings.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx      <= 1'b1;
            r_sent    <= 1'b0;
            r_bitcnt  <= 3'd0;
            r_byte    <= 8'h00;
            r_par_en  <= 1'b0;
            r_big_end <= 1'b0;
            r_parity  <= 1'b0;
        end else begin
            r_tx     <= w_tx_nxt;
            r_sent   <= w_sent_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            if (w_pop) begin
                r_byte    <= w_fifo_data;
                r_par_en  <= p_ParityEnable_i;
                r_big_end <= p_BigEnd_i;
                r_parity  <= parity_bit(w_fifo_data, ParityMethod_i);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed and randomized bench for uart_tx_core. Expected line sequences
// come from a frame model built from the framing rules; FIFO flags and
// levels are tracked by plain counting.
module tb_uart_tx_core;

    logic        clk;
    logic        rst;
    logic [7:0]  Data_i;
    logic        n_We_i;
    logic        n_Clr_i;
    logic        p_Enable_i;
    logic        p_ParityEnable_i;
    logic        p_BigEnd_i;
    logic        ParityMethod_i;
    wire         BaudSig_i;
    logic        p_Empty_o;
    logic        p_NearFull_o;
    logic        p_Full_o;
    logic        p_Over_o;
    logic [15:0] TxFifoLevel_o;
    logic        p_Busy_o;
    logic        p_ByteSent_o;
    logic        Tx_o;
    logic [4:0]  State_o;
    logic        two_stop;
`ifdef UART_TX_TWO_STOP_EN
    logic        p_TwoStop_i;
    assign p_TwoStop_i = two_stop;
`endif

    logic        baud_auto;
    logic        baud_man;
    logic        baud_gen;
    int          baud_cnt;
    int          errors = 0;
    int          checks = 0;
    int          sent_cnt = 0;
    int          sent_ref;
    logic        exp_q[$];

    localparam logic [4:0] ST_INTERVAL = 5'b00001;

    assign BaudSig_i = baud_auto ? baud_gen : baud_man;

    uart_tx_core dut (
        .clk              (clk),
        .rst              (rst),
        .Data_i           (Data_i),
        .n_We_i           (n_We_i),
        .n_Clr_i          (n_Clr_i),
        .p_Enable_i       (p_Enable_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .ParityMethod_i   (ParityMethod_i),
        .BaudSig_i        (BaudSig_i),
`ifdef UART_TX_TWO_STOP_EN
        .p_TwoStop_i      (p_TwoStop_i),
`endif
        .p_Empty_o        (p_Empty_o),
        .p_NearFull_o     (p_NearFull_o),
        .p_Full_o         (p_Full_o),
        .p_Over_o         (p_Over_o),
        .TxFifoLevel_o    (TxFifoLevel_o),
        .p_Busy_o         (p_Busy_o),
        .p_ByteSent_o     (p_ByteSent_o),
        .Tx_o             (Tx_o),
        .State_o          (State_o)
    );

    // Clock and free-running bit-period pulse (one every 16 clk).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_gen = 1'b0;
        baud_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_gen = (baud_cnt == 15);
            baud_cnt = (baud_cnt + 1) % 16;
        end
    end

    always @(posedge clk) begin
        if (p_ByteSent_o === 1'b1) sent_cnt <= sent_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        Data_i = d;
        n_We_i = 1'b0;
        tick();
        n_We_i = 1'b1;
    endtask

    // Frame model: start 0, data in chosen order, parity giving an even
    // (or odd) total count of ones, then stop 1 (twice when two_stop).
    task automatic push_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(p_BigEnd_i ? b[7-k] : b[k]);
        if (p_ParityEnable_i)
            exp_q.push_back(((ones % 2) == 1) ^ ParityMethod_i);
        exp_q.push_back(1'b1);
        if (two_stop) exp_q.push_back(1'b1);
    endtask

    // Find the start edge, then sample mid-period for every expected bit.
    task automatic check_stream(input string tag, input int drop_at);
        int t;
        int n;
        n = exp_q.size();
        t = 0;
        while (Tx_o !== 1'b0 && t < 400) begin
            tick();
            t++;
        end
        check({tag, "_start"}, Tx_o, 0);
        for (int i = 0; i < n; i++) begin
            repeat (8) tick();
            check($sformatf("%s_bit%0d", tag, i), Tx_o, exp_q[i]);
            if (i == drop_at) p_Enable_i = 1'b0;
            repeat (8) tick();
        end
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (p_Busy_o !== 1'b0 && t < budget) begin
            tick();
            t++;
        end
        check(tag, p_Busy_o, 0);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b0;
        Data_i = 8'h00;
        n_We_i = 1'b1;
        n_Clr_i = 1'b1;
        p_Enable_i = 1'b0;
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i = 1'b0;
        ParityMethod_i = 1'b0;
        two_stop = 1'b0;
        baud_auto = 1'b1;
        baud_man = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_tx", Tx_o, 1);
        check("rst_empty", p_Empty_o, 1);
        check("rst_full", p_Full_o, 0);
        check("rst_near", p_NearFull_o, 0);
        check("rst_over", p_Over_o, 0);
        check("rst_level", TxFifoLevel_o, 0);
        check("rst_busy", p_Busy_o, 0);
        check("rst_sent", p_ByteSent_o, 0);
        check("rst_state", State_o, ST_INTERVAL);
        rst = 1'b1;
        tick();

        // Parity even, LSB first, 0xA5
        p_ParityEnable_i = 1'b1;
        ParityMethod_i = 1'b0;
        p_BigEnd_i = 1'b0;
        p_Enable_i = 1'b1;
        sent_ref = sent_cnt;
        push_frame(8'hA5);
        write_byte(8'hA5);
        check_stream("a5", -1);
        wait_idle("a5_idle", 64);
        tick(); tick();
        check("a5_sent", sent_cnt, sent_ref + 1);
        check("a5_empty", p_Empty_o, 1);

        // Parity odd, MSB first, 0x01
        ParityMethod_i = 1'b1;
        p_BigEnd_i = 1'b1;
        sent_ref = sent_cnt;
        push_frame(8'h01);
        write_byte(8'h01);
        check_stream("x01", -1);
        wait_idle("x01_idle", 64);
        tick(); tick();
        check("x01_sent", sent_cnt, sent_ref + 1);

        // No parity, two bytes back to back
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i = 1'b0;
        sent_ref = sent_cnt;
        push_frame(8'h55);
        push_frame(8'hAA);
        write_byte(8'h55);
        write_byte(8'hAA);
        check_stream("b2b", -1);
        wait_idle("b2b_idle", 64);
        tick(); tick();
        check("b2b_sent", sent_cnt, sent_ref + 2);

        // Random single bytes with random frame settings
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom_range(0, 255));
            p_ParityEnable_i = 1'($urandom_range(0, 1));
            p_BigEnd_i = 1'($urandom_range(0, 1));
            ParityMethod_i = 1'($urandom_range(0, 1));
            sent_ref = sent_cnt;
            push_frame(b);
            write_byte(b);
            check_stream($sformatf("rnd%0d", r), -1);
            wait_idle("rnd_idle", 64);
            tick(); tick();
            check("rnd_sent", sent_cnt, sent_ref + 1);
        end

        // Random burst of three bytes
        p_ParityEnable_i = 1'($urandom_range(0, 1));
        p_BigEnd_i = 1'($urandom_range(0, 1));
        ParityMethod_i = 1'($urandom_range(0, 1));
        sent_ref = sent_cnt;
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom_range(0, 255));
            push_frame(b);
            write_byte(b);
        end
        check_stream("burst", -1);
        wait_idle("burst_idle", 64);
        tick(); tick();
        check("burst_sent", sent_cnt, sent_ref + 3);

        // Fill past full with transmitter disabled
        p_Enable_i = 1'b0;
        for (int i = 0; i < 129; i++) begin
            write_byte(8'($urandom_range(0, 255)));
            if (i == 118) check("near_119", p_NearFull_o, 0);
            if (i == 119) check("near_120", p_NearFull_o, 1);
            if (i == 127) begin
                check("full_128", p_Full_o, 1);
                check("over_128", p_Over_o, 0);
            end
        end
        check("ovf_level", TxFifoLevel_o, 128);
        check("ovf_full", p_Full_o, 1);
        check("ovf_over", p_Over_o, 1);
        n_Clr_i = 1'b0;
        tick();
        n_Clr_i = 1'b1;
        check("clr_level", TxFifoLevel_o, 0);
        check("clr_empty", p_Empty_o, 1);
        check("clr_over", p_Over_o, 0);
        check("clr_tx", Tx_o, 1);

        // Pop and write together while full
        for (int i = 0; i < 128; i++) write_byte(8'(i));
        check("refill_full", p_Full_o, 1);
        baud_auto = 1'b0;
        p_Enable_i = 1'b1;
        baud_man = 1'b1;
        Data_i = 8'h3C;
        n_We_i = 1'b0;
        tick();
        baud_man = 1'b0;
        n_We_i = 1'b1;
        p_Enable_i = 1'b0;
        check("popwr_level", TxFifoLevel_o, 128);
        check("popwr_over", p_Over_o, 0);
        check("popwr_busy", p_Busy_o, 1);
        baud_auto = 1'b1;
        wait_idle("popwr_idle", 400);

        // Clear with a write in the same clock
        n_Clr_i = 1'b0;
        n_We_i = 1'b0;
        tick();
        n_Clr_i = 1'b1;
        n_We_i = 1'b1;
        check("clrwr_level", TxFifoLevel_o, 0);
        check("clrwr_empty", p_Empty_o, 1);

        // Pop and write together at level 1
        baud_auto = 1'b0;
        write_byte(8'h11);
        p_Enable_i = 1'b1;
        baud_man = 1'b1;
        Data_i = 8'h22;
        n_We_i = 1'b0;
        tick();
        baud_man = 1'b0;
        n_We_i = 1'b1;
        p_Enable_i = 1'b0;
        check("lvl1_level", TxFifoLevel_o, 1);
        baud_auto = 1'b1;
        wait_idle("lvl1_idle", 400);
        n_Clr_i = 1'b0;
        tick();
        n_Clr_i = 1'b1;

        // Enable dropped during data bit 3 with two bytes queued
        p_ParityEnable_i = 1'b1;
        ParityMethod_i = 1'b0;
        p_BigEnd_i = 1'b0;
        write_byte(8'hC3);
        write_byte(8'h5A);
        sent_ref = sent_cnt;
        push_frame(8'hC3);
        p_Enable_i = 1'b1;
        check_stream("drop1", 4);
        wait_idle("drop_idle", 64);
        repeat (64) tick();
        check("drop_level", TxFifoLevel_o, 1);
        check("drop_tx", Tx_o, 1);
        check("drop_busy", p_Busy_o, 0);
        check("drop_sent", sent_cnt, sent_ref + 1);
        push_frame(8'h5A);
        p_Enable_i = 1'b1;
        check_stream("drop2", -1);
        wait_idle("drop2_idle", 64);
        check("drop2_empty", p_Empty_o, 1);

`ifdef UART_TX_TWO_STOP_EN
        // Two stop periods
        two_stop = 1'b1;
        p_ParityEnable_i = 1'b0;
        sent_ref = sent_cnt;
        push_frame(8'h96);
        write_byte(8'h96);
        check_stream("two_stop", -1);
        wait_idle("two_stop_idle", 64);
        tick(); tick();
        check("two_stop_sent", sent_cnt, sent_ref + 1);
        two_stop = 1'b0;
`endif

        // Reset in the middle of the data bits
        write_byte(8'h00);
        begin
            int t;
            t = 0;
            while (Tx_o !== 1'b0 && t < 400) begin
                tick();
                t++;
            end
        end
        repeat (40) tick();
        check("mid_busy", p_Busy_o, 1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_tx", Tx_o, 1);
        check("arst_level", TxFifoLevel_o, 0);
        check("arst_busy", p_Busy_o, 0);
        check("arst_state", State_o, ST_INTERVAL);
        check("arst_empty", p_Empty_o, 1);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        check("post_rst_tx", Tx_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
